// File: rtl/timer_sequencer_pkg.sv
// Shared definitions for the timer sequencer: FSM state encoding and the
// command set with its fixed priority (abort > pause > start).
package timer_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_START = 2'b01,
    CMD_PAUSE = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_t;

  // Collapse the raw request lines into the single winning command.
  function automatic cmd_t pick_cmd(input logic abort_req,
                                    input logic pause_req,
                                    input logic start_req);
    if (abort_req)      return CMD_ABORT;
    else if (pause_req) return CMD_PAUSE;
    else if (start_req) return CMD_START;
    else                return CMD_NONE;
  endfunction

endpackage

// File: rtl/timer_sequencer_prescale_tick.sv
// Prescaler: counts active cycles and fires a tick when the count reaches
// the limit, after which it restarts from zero.
module timer_sequencer_prescale_tick #(
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         run,
  input  logic         clear,
  input  logic [P-1:0] limit,
  output logic         tick
);

  logic [P-1:0] cnt_reg;

  assign tick = run && (cnt_reg == limit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (run) begin
      cnt_reg <= tick ? '0 : cnt_reg + P'(1);
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Programmable timer: start/pause/resume/abort control around a prescaled
// N-bit up-counter with one-shot or periodic terminal-count handling.
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic         periodic,
  input  logic [P-1:0] prescale,
  input  logic [N-1:0] terminal,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         paused,
  output logic         done
);

  state_t       state_reg, state_next;
  logic [N-1:0] count_reg, count_next;
  logic         done_reg, done_next;
  logic         busy_reg, paused_reg;
  logic [P-1:0] prescale_reg;
  logic [N-1:0] terminal_reg;
  logic         periodic_reg;
  cmd_t         cmd;
  logic         launch;
  logic         pre_run, pre_clear, tick;

  // Pause only means something while running; elsewhere it must not mask start.
  assign cmd       = pick_cmd(abort, pause && (state_reg == ST_RUN), start);
  assign launch    = (state_reg == ST_IDLE) && (cmd == CMD_START);
  assign pre_run   = (state_reg == ST_RUN) && (cmd != CMD_ABORT) && (cmd != CMD_PAUSE);
  assign pre_clear = (cmd == CMD_ABORT) || launch;

  timer_sequencer_prescale_tick #(.P(P)) u_prescale_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (pre_run),
    .clear   (pre_clear),
    .limit   (prescale_reg),
    .tick    (tick)
  );

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    if (cmd == CMD_ABORT) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (cmd == CMD_START) begin
            state_next = ST_RUN;
            count_next = '0;
          end
        end
        ST_RUN: begin
          if (cmd == CMD_PAUSE) begin
            state_next = ST_PAUSED;
          end else if (tick) begin
            if (count_reg == terminal_reg) begin
              count_next = '0;
              done_next  = 1'b1;
              if (!periodic_reg) state_next = ST_IDLE;
            end else begin
              count_next = count_reg + N'(1);
            end
          end
        end
        ST_PAUSED: begin
          if (cmd == CMD_START) state_next = ST_RUN;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      paused_reg   <= 1'b0;
      prescale_reg <= '0;
      terminal_reg <= '0;
      periodic_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      done_reg   <= done_next;
      busy_reg   <= (state_next != ST_IDLE);
      paused_reg <= (state_next == ST_PAUSED);
      if (launch) begin
        prescale_reg <= prescale;
        terminal_reg <= terminal;
        periodic_reg <= periodic;
      end
    end
  end

  assign count  = count_reg;
  assign busy   = busy_reg;
  assign paused = paused_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_timer_sequencer.sv
// Randomized and directed bench for timer_sequencer, checked against an
// elapsed-active-cycle arithmetic model of the timer.
module tb_timer_sequencer;

  localparam int N = 4;
  localparam int P = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0, pause = 1'b0, abort = 1'b0, periodic = 1'b0;
  logic [P-1:0] prescale = '0;
  logic [N-1:0] terminal = '0;
  logic [N-1:0] count;
  logic         busy, paused, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0=idle 1=run 2=paused; e = active run cycles since start.
  int     m_mode = 0;
  longint m_e = 0;
  longint m_p = 0, m_t = 0;
  logic   m_per = 1'b0;
  logic   m_done = 1'b0;

  timer_sequencer #(.N(N), .P(P)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .abort(abort),
    .periodic(periodic), .prescale(prescale), .terminal(terminal),
    .count(count), .busy(busy), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_count();
    if (m_mode == 0) return 0;
    return (m_e / (m_p + 1)) % (m_t + 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_e = 0; m_p = 0; m_t = 0; m_per = 1'b0; m_done = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, compare all outputs.
  task automatic cyc(input logic s, input logic pa, input logic ab, input logic per,
                     input logic [P-1:0] pre, input logic [N-1:0] term);
    @(negedge clk);
    start = s; pause = pa; abort = ab; periodic = per; prescale = pre; terminal = term;
    @(posedge clk);
    m_done = 1'b0;
    if (ab) begin
      m_mode = 0; m_e = 0;
    end else if (m_mode == 0) begin
      if (s) begin
        m_p = longint'(pre); m_t = longint'(term); m_per = per; m_e = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (pa) m_mode = 2;
      else begin
        m_e++;
        if (m_e % ((m_t + 1) * (m_p + 1)) == 0) begin
          m_done = 1'b1;
          if (!m_per) begin m_mode = 0; m_e = 0; end
        end
      end
    end else if (s) begin
      m_mode = 1;
    end
    #1;
    check_eq("count", 32'(count), 32'(exp_count()));
    check_eq("busy", 32'(busy), 32'(m_mode != 0));
    check_eq("paused", 32'(paused), 32'(m_mode == 2));
    check_eq("done", 32'(done), 32'(m_done));
  endtask

  task automatic quiet();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Idle cycles until done is seen; returns cycles taken, flags timeout.
  task automatic run_until_done(input int limit, output int cycles, output int max_cnt);
    cycles = 0; max_cnt = 0;
    while (cycles < limit) begin
      quiet();
      cycles++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (done) break;
    end
    if (cycles >= limit && !done) check_eq("timeout_done", 32'(done), 32'd1);
  endtask

  initial begin
    int cycles, max_cnt, pulses;

    #12;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_paused", 32'(paused), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    quiet();

    // One-shot, prescale 0, terminal 3
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd3);
    for (int i = 1; i <= 3; i++) begin
      quiet();
      check_eq("os_count_step", 32'(count), 32'(i));
    end
    quiet();
    check_eq("os_done", 32'(done), 32'd1);
    check_eq("os_busy_fall", 32'(busy), 32'd0);
    check_eq("os_count_zero", 32'(count), 32'd0);
    quiet();
    check_eq("os_done_one_cycle", 32'(done), 32'd0);

    // Periodic, prescale 2, terminal 1: done every 6 cycles
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 4'd1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      quiet();
      if (done) pulses++;
      check_eq("per_busy", 32'(busy), 32'd1);
    end
    check_eq("per_pulses", 32'(pulses), 32'd5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

    // Pause/resume: prescale 3, terminal 5 (24 active cycles) plus 10 held
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 4'd5);
    for (int i = 0; i < 9; i++) quiet();
    check_eq("pr_count_before", 32'(count), 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      quiet();
      check_eq("pr_frozen", 32'(count), 32'd2);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd9, 4'd9);
    run_until_done(100, cycles, max_cnt);
    check_eq("pr_total_cycles", 32'(9 + 10 + cycles), 32'd34);

    // terminal 0, prescale 255, periodic: done every tick
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 4'd0);
    pulses = 0;
    for (int i = 0; i < 3 * 256; i++) begin
      quiet();
      if (done) pulses++;
    end
    check_eq("t0_pulses", 32'(pulses), 32'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

    // terminal 15, prescale 255, one-shot: full range
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 4'd15);
    run_until_done(5000, cycles, max_cnt);
    check_eq("full_cycles", 32'(cycles), 32'd4096);
    check_eq("full_max_count", 32'(max_cnt), 32'd15);

    // Abort on the terminal tick
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd3);
    for (int i = 0; i < 3; i++) quiet();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    check_eq("abort_tc_done", 32'(done), 32'd0);
    check_eq("abort_tc_busy", 32'(busy), 32'd0);
    quiet();
    check_eq("abort_tc_done_after", 32'(done), 32'd0);

    // pause+start in RUN: pause wins
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'd7);
    quiet(); quiet();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    check_eq("pause_wins", 32'(paused), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

    // New config during RUN is ignored: still 3 cycles to done
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 4'd9);
    run_until_done(50, cycles, max_cnt);
    check_eq("cfg_ignored_cycles", 32'(cycles + 1), 32'd3);
    check_eq("cfg_ignored_oneshot", 32'(busy), 32'd0);

    // Async reset between edges mid-run
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 4'd9);
    for (int i = 0; i < 5; i++) quiet();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 4'd1);
    for (int i = 0; i < 6; i++) quiet();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

    // Random command/config traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cyc(r >= 10 && r < 30, r >= 3 && r < 10, r < 3, 1'($urandom_range(0, 1)),
          P'($urandom_range(0, 3)), N'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
